// File: rtl/apb_slave_adapter_ws.sv
// APB4 slave adapter with wait states: address-window decode, optional secure-only
// access, registered APB responses. Define APB_ADAPTER_TIMEOUT_EN to build the native-ack timeout.
module apb_slave_adapter_ws #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] ADDR_LO        = '0,
  parameter logic [ADDR_WIDTH-1:0] ADDR_HI        = 'hFFF,
  parameter bit                    SECURE_ONLY    = 1'b0,
  parameter int                    TIMEOUT_CYCLES = 16
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [2:0]              pprot,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr,
  output logic [ADDR_WIDTH-1:0]   reg_addr,
  output logic [DATA_WIDTH-1:0]   reg_wdata,
  output logic [DATA_WIDTH/8-1:0] reg_be,
  output logic                    reg_we,
  output logic                    reg_re,
  input  logic                    reg_ack,
  input  logic [DATA_WIDTH-1:0]   reg_rdata,
  input  logic                    reg_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t                  state_q, state_d;
  logic                    write_q;
  logic                    start_req, capture, reject, timeout_hit;
  logic                    pslverr_d;
  logic [DATA_WIDTH-1:0]   prdata_d;
  logic [ADDR_WIDTH:0]     lo_diff;

  // The borrow out of paddr - ADDR_LO flags addresses below the window; the
  // remaining bits are the window offset presented as reg_addr.
  assign lo_diff = {1'b0, paddr} - {1'b0, ADDR_LO};
  assign reject  = lo_diff[ADDR_WIDTH] || (paddr > ADDR_HI) || (SECURE_ONLY && pprot[1]);

  logic unused_prot;
  assign unused_prot = pprot[2] ^ pprot[0];

`ifdef APB_ADAPTER_TIMEOUT_EN
  localparam int                TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt_q;

  // Reaching TMO_LAST in an ack-less REQ/WAIT cycle means TIMEOUT_CYCLES cycles have gone by.
  assign timeout_hit = (tmo_cnt_q == TMO_LAST);

  always_ff @(posedge pclk) begin
    if (preset) begin
      tmo_cnt_q <= '0;
    end else if (start_req) begin
      tmo_cnt_q <= '0;
    end else if ((state_q == REQ || state_q == WAIT) && !reg_ack) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state_q;
    start_req = 1'b0;
    capture   = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          capture = 1'b1;
          if (reject) begin
            state_d   = RESP;
            pslverr_d = 1'b1;
          end else begin
            state_d   = REQ;
            start_req = 1'b1;
          end
        end
      end
      REQ, WAIT: begin
        // An ack in the timeout cycle takes priority over the timeout.
        if (reg_ack) begin
          state_d   = RESP;
          pslverr_d = reg_err;
          prdata_d  = write_q ? '0 : reg_rdata;
        end else if (timeout_hit) begin
          state_d   = RESP;
          pslverr_d = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
    if (preset) begin
      state_q   <= IDLE;
      write_q   <= 1'b0;
      pready    <= 1'b0;
      pslverr   <= 1'b0;
      prdata    <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_be    <= '0;
    end else begin
      state_q <= state_d;
      pready  <= (state_d == RESP);
      pslverr <= pslverr_d;
      prdata  <= prdata_d;
      reg_we  <= start_req && pwrite;
      reg_re  <= start_req && !pwrite;
      if (capture) begin
        write_q   <= pwrite;
        reg_addr  <= lo_diff[ADDR_WIDTH-1:0];
        reg_wdata <= pwdata;
        reg_be    <= pwrite ? pstrb : '1;
      end
    end
  end

endmodule
